// File: rtl/midi_message_parser_pkg.sv
// Shared MIDI types: channel-voice message layout, status byte boundaries and data-byte counts.
package midi_message_parser_pkg;

  typedef enum logic [3:0] {
    NOTE_OFF         = 4'h8,
    NOTE_ON          = 4'h9,
    POLY_PRESSURE    = 4'hA,
    CONTROL_CHANGE   = 4'hB,
    PROGRAM_CHANGE   = 4'hC,
    CHANNEL_PRESSURE = 4'hD,
    PITCH_BEND       = 4'hE
  } message_type_t;

  typedef struct packed {
    message_type_t message_type;
    logic [3:0]    channel;
    logic [7:0]    data_byte1;
    logic [7:0]    data_byte2;
  } message_t;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  function automatic logic [1:0] data_bytes_needed(input message_type_t t);
    case (t)
      PROGRAM_CHANGE, CHANNEL_PRESSURE: data_bytes_needed = 2'd1;
      default:                          data_bytes_needed = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/midi_message_parser.sv
// MIDI byte stream to channel-voice messages; 1-cycle latency from final byte, no backpressure.
// Optional MIDI_NOTE_ON_VELOCITY_ZERO_AS_OFF_EN reports NOTE_ON velocity 0 as NOTE_OFF.
module midi_message_parser
  import midi_message_parser_pkg::*;
#(
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] byte_data,
  input  logic       byte_ready,
  output message_t   message,
  output logic       message_ready
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t     state_q, state_d;
  logic [3:0] rs_type_q, rs_type_d;
  logic [3:0] rs_chan_q, rs_chan_d;
  logic [7:0] d1_q, d1_d;
  message_t   message_q, message_d;
  logic       message_ready_q, message_ready_d;

  logic       emit;
  logic [7:0] emit_d1, emit_d2;
  message_t   msg_c;

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q         <= IDLE;
      rs_type_q       <= 4'h0;
      rs_chan_q       <= 4'h0;
      d1_q            <= 8'h00;
      message_q       <= '0;
      message_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rs_type_q       <= rs_type_d;
      rs_chan_q       <= rs_chan_d;
      d1_q            <= d1_d;
      message_q       <= message_d;
      message_ready_q <= message_ready_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rs_type_d       = rs_type_q;
    rs_chan_d       = rs_chan_q;
    d1_d            = d1_q;
    emit            = 1'b0;
    emit_d1         = 8'h00;
    emit_d2         = 8'h00;

    if (byte_ready) begin
      if (byte_data >= REALTIME_MIN) begin
        // real-time bytes are transparent to everything, even mid-message
      end else if (byte_data >= SYSEX_START && byte_data <= SYSEX_END) begin
        rs_type_d = 4'h0;
        rs_chan_d = 4'h0;
        state_d   = (byte_data == SYSEX_START) ? SYSEX : IDLE;
      end else if (byte_data[7]) begin
        rs_type_d = byte_data[7:4];
        rs_chan_d = byte_data[3:0];
        d1_d      = 8'h00;
        state_d   = WAIT_D1;
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d = byte_data;
            if (data_bytes_needed(message_type_t'(rs_type_q)) == 2'd1) begin
              emit    = 1'b1;
              emit_d1 = byte_data;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1_q;
            emit_d2 = byte_data;
            state_d = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    msg_c.message_type = message_type_t'(rs_type_q);
    msg_c.channel      = rs_chan_q;
    msg_c.data_byte1   = emit_d1;
    msg_c.data_byte2   = emit_d2;
`ifdef MIDI_NOTE_ON_VELOCITY_ZERO_AS_OFF_EN
    // running status keeps NOTE_ON; only the reported type changes
    if (msg_c.message_type == NOTE_ON && emit_d2 == 8'h00) begin
      msg_c.message_type = NOTE_OFF;
    end
`endif
    message_d       = message_q;
    message_ready_d = 1'b0;
    if (emit && CHANNEL_MASK[rs_chan_q]) begin
      message_d       = msg_c;
      message_ready_d = 1'b1;
    end
  end

  assign message       = message_q;
  assign message_ready = message_ready_q;

endmodule

// File: doc/midi_message_parser.md
Name: midi_message_parser

Overview:
- Converts the raw MIDI byte stream from the UART receiver into complete channel-voice messages (message_t plus a one-cycle message_ready strobe).
- Sits directly upstream of the dispatcher, which turns NOTE_ON/NOTE_OFF messages into per-pipeline note changes.
- Handles running status, interleaved real-time bytes and SysEx skipping, so downstream logic only ever sees whole, well-formed messages.

Parameters:
- CHANNEL_MASK, 16'hFFFF, bit n set = accept channel n; messages on cleared channels are dropped silently.

Ports:
- clock_50_000_000  input  1  system clock.
- reset_l  input  1  reset, asynchronous, active-low.
- byte_data  input  8  received MIDI byte.
- byte_ready  input  1  one-cycle strobe: byte_data is valid. May be high on consecutive cycles.
- message  output  24 (message_t)  fields: message_type[3:0] = status high nibble, channel[3:0], data_byte1[7:0], data_byte2[7:0].
- message_ready  output  1  one-cycle strobe: message holds a complete message.

Behaviour:
- Reset (async assert, sync release): state=IDLE, running status cleared, message='0, message_ready=0.
- Byte classes, evaluated only when byte_ready=1:
  - 0x80-0xEF: channel status.
  - 0xF0-0xF7: system common.
  - 0xF8-0xFF: real-time.
  - 0x00-0x7F: data.
- Data-byte count by message_type:
  - 0x8, 0x9, 0xA, 0xB, 0xE: 2 bytes.
  - 0xC, 0xD: 1 byte.
- States:
  - IDLE: no running status; data bytes are discarded.
  - WAIT_D1
  - WAIT_D2
  - SYSEX
- Channel status byte, from any state: latch type/channel as running status, go to WAIT_D1, discard any partial data.
- WAIT_D1 + data byte:
  - Store it in data_byte1.
  - 1-byte type: emit, stay in WAIT_D1.
  - 2-byte type: go to WAIT_D2.
- WAIT_D2 + data byte: store it in data_byte2, emit, return to WAIT_D1 (running status retained).
- Emit:
  - On the clock edge after the completing byte, message gets the assembled fields and message_ready=1 for exactly one cycle. Latency is 1 cycle from the final byte_ready.
  - For 1-byte types, data_byte2=0.
  - If CHANNEL_MASK[channel]=0, the message is not emitted: message and message_ready are unchanged, but state advances normally.
- 0xF0: clear running status, go to SYSEX. SYSEX discards data bytes. 0xF7 or any other system common byte returns to IDLE; a channel status byte goes to WAIT_D1.
- 0xF1-0xF7 outside SYSEX: clear running status, go to IDLE. Data bytes that follow are discarded.
- Real-time bytes: ignored completely. No change to state, running status or partial data, including mid-message and mid-SysEx.
- message holds its last value between strobes. message_ready is never high on two consecutive cycles unless two messages complete on consecutive cycles (back-to-back 1-byte messages).
- byte_ready low: no state change.
- Reset mid-message: partial message lost, no strobe.

Optional Feature:
- Macro: MIDI_NOTE_ON_VELOCITY_ZERO_AS_OFF_EN.
- Defined: a completed NOTE_ON (0x9) with data_byte2==0 is emitted with message_type=NOTE_OFF (0x8). Channel and data bytes are unchanged, and running status stays 0x9.
- Undefined: emitted verbatim as NOTE_ON, velocity 0.

Decomposition:
- Add to shared package MIDI:
  - message_type_t enum (NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_PRESSURE=4'hA, CONTROL_CHANGE=4'hB, PROGRAM_CHANGE=4'hC, CHANNEL_PRESSURE=4'hD, PITCH_BEND=4'hE).
  - message_t packed struct.
  - Constants SYSEX_START=8'hF0, SYSEX_END=8'hF7, REALTIME_MIN=8'hF8.
  - Function data_bytes_needed(message_type_t).
- Parser state enum is local.
- No sub-module; one FSM plus a datapath register block.

Test Plan:
- 0x90,0x3C,0x64 -> one strobe, cycle after last byte: type 9, ch 0, d1 0x3C, d2 0x64.
- 0x91,0x40,0x7F,0x41,0x7F (running status) -> two strobes: (9,1,0x40,0x7F), then (9,1,0x41,0x7F).
- 0x80,0xF8,0x3C,0xFE,0x00 -> real-time ignored; one strobe (8,0,0x3C,0x00).
- 0xF0,0x12,0x34,0xF7,0x3C,0x40 -> no strobe (SysEx skipped, then no running status). Then 0xC5,0x07,0x08 -> two strobes (C,5,0x07,0x00), then (C,5,0x08,0x00), on back-to-back cycles when byte_ready is back-to-back.
- CHANNEL_MASK=16'h0001: 0x92,0x3C,0x64 -> no strobe; 0x90,0x3C,0x64 -> strobe. Also: reset_l pulsed low between 0x90 and 0x3C -> no strobe, outputs return to 0.
- 0x90,0x3C,0x00 -> with macro: type 8; without macro: type 9, d2 0x00.
